// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: shares one spi_master serializer between the two DAC channels.
// Each channel posts one pending sample; pending channels are granted round-robin,
// the serializer is launched with a one-cycle strobe, the serializer's load pulse
// is routed to the granted channel, and every frame is followed by an idle gap.
//
// Handshake: wr0_in/wr1_in are one-cycle strobes with no back-pressure. A write is
// captured on the clock edge where it is high. busy_out tells the producer whether
// a value is still queued or in flight. spi_strob_out is a one-cycle launch pulse,
// and spi_load_in is honoured only while a frame is waiting for completion.
//
// Optional build macro: DAC_ARB_COALESCE_EN. When it is defined, a write to a channel
// that is already pending replaces the queued value. When it is not defined, that
// write is dropped and the channel's overrun flag is set.

module dac_spi_arbiter #(
    parameter int W_LENGTH = 10,
    parameter int TIMEOUT  = 255,
    parameter int GAP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr0_in,
    input  logic [W_LENGTH-1:0] value0_in,
    input  logic                wr1_in,
    input  logic [W_LENGTH-1:0] value1_in,
    input  logic                clr_in,
    output logic [W_LENGTH-1:0] spi_value_out,
    output logic                spi_strob_out,
    input  logic                spi_load_in,
    output logic [1:0]          load_out,
    output logic [1:0]          busy_out,
    output logic [1:0]          done_out,
    output logic [1:0]          overrun_out,
    output logic                timeout_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_INIT = 16'(GAP - 1);

    state_t              state;
    logic                grant;
    logic                last_grant;
    logic [1:0]          pending;
    logic [W_LENGTH-1:0] stored [2];
    logic [15:0]         tmo_cnt;
    logic [15:0]         gap_cnt;

    logic [W_LENGTH-1:0] val_in [2];
    logic [1:0]          wr;
    logic                sel;
    logic [1:0]          take;
    logic [1:0]          accept;
    logic [1:0]          overrun_set;
    logic                tmo_fire;

    assign val_in[0] = value0_in;
    assign val_in[1] = value1_in;
    assign wr        = {wr1_in, wr0_in};

    // Grant selection in IDLE: a lone pending channel wins, and on a tie the channel not served last wins
    always_comb begin
        sel  = 1'b0;
        take = 2'b00;
        if (state == S_IDLE && pending != 2'b00) begin
            sel  = (pending == 2'b11) ? ~last_grant : pending[1];
            take = sel ? 2'b10 : 2'b01;
        end
    end

    // Write acceptance: a write in the same cycle the grant empties the slot always lands
    always_comb begin
`ifdef DAC_ARB_COALESCE_EN
        accept      = wr;
        overrun_set = 2'b00;
`else
        accept      = wr & (~pending | take);
        overrun_set = wr & pending & ~take;
`endif
    end

    // A frame times out only if the load pulse is absent in the last allowed WAIT cycle
    assign tmo_fire = (state == S_WAIT) && !spi_load_in && (tmo_cnt == TMO_LAST);

    // The load pulse is forwarded only while the granted frame is awaiting completion
    assign load_out = (state == S_WAIT && spi_load_in) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    // A channel is busy while it is queued or while its own frame occupies the serializer
    assign busy_out = pending | ((state != S_IDLE) ? (grant ? 2'b10 : 2'b01) : 2'b00);

    // Per-channel pending slot: capture accepted writes and release the slot on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 2'b00;
            for (int g = 0; g < 2; g++) stored[g] <= '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (accept[g]) begin
                    pending[g] <= 1'b1;
                    stored[g]  <= val_in[g];
                end else if (take[g]) begin
                    pending[g] <= 1'b0;
                end
            end
        end
    end

    // Frame sequencer: grant, launch, wait for load or timeout, then enforce the idle gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            spi_value_out <= '0;
            spi_strob_out <= 1'b0;
            done_out      <= 2'b00;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
        end else begin
            spi_strob_out <= 1'b0;
            done_out      <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (pending != 2'b00) begin
                        grant         <= sel;
                        last_grant    <= sel;
                        spi_value_out <= stored[sel];
                        spi_strob_out <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_load_in) begin
                        done_out <= grant ? 2'b10 : 2'b01;
                        gap_cnt  <= GAP_INIT;
                        state    <= S_GAP;
                    end else if (tmo_fire) begin
                        gap_cnt <= GAP_INIT;
                        state   <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 16'd0) state <= S_IDLE;
                    else                  gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky status flags: a clear is overridden by a set event in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_out <= 2'b00;
            timeout_out <= 1'b0;
        end else begin
            overrun_out <= (clr_in ? 2'b00 : overrun_out) | overrun_set;
            timeout_out <= (clr_in ? 1'b0 : timeout_out) | tmo_fire;
        end
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Bench for dac_spi_arbiter: directed scenarios with literal expectations, plus a
// timestamp-based reference model compared against every output on every cycle.
// Optional build macro: DAC_ARB_COALESCE_EN selects the coalescing expectations.

module tb_dac_spi_arbiter;

    localparam int W   = 10;
    localparam int TMO = 255;
    localparam int GP  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr0 = 1'b0;
    logic         wr1 = 1'b0;
    logic [W-1:0] v0  = '0;
    logic [W-1:0] v1  = '0;
    logic         clr = 1'b0;
    logic         load = 1'b0;

    logic [W-1:0] spi_value;
    logic         spi_strob;
    logic [1:0]   load_out;
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [1:0]   overrun;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    dac_spi_arbiter #(.W_LENGTH(W), .TIMEOUT(TMO), .GAP(GP)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr0_in       (wr0),
        .value0_in    (v0),
        .wr1_in       (wr1),
        .value1_in    (v1),
        .clr_in       (clr),
        .spi_value_out(spi_value),
        .spi_strob_out(spi_strob),
        .spi_load_in  (load),
        .load_out     (load_out),
        .busy_out     (busy),
        .done_out     (done),
        .overrun_out  (overrun),
        .timeout_out  (timeout)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: advance to just after the next rising edge and drop the one-cycle inputs
    task automatic step();
        @(posedge clk);
        #1;
        wr0  = 1'b0;
        wr1  = 1'b0;
        clr  = 1'b0;
        load = 1'b0;
        rst  = 1'b0;
    endtask

    // Cycles from the current one until spi_strob_out is seen (1 = next cycle)
    task automatic wait_strobe(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            @(negedge clk);
            n++;
            if (spi_strob) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_strobe: no spi_strob_out within 600 cycles, got 0 expected 1");
    endtask

    // Pulse spi_load_in d cycles after the current one and check routing and completion
    task automatic finish(input int d, input logic [1:0] ch);
        repeat (d) step();
        load = 1'b1;
        @(negedge clk);
        chk("load_out", 32'(load_out), 32'(ch));
        step();
        @(negedge clk);
        chk("done_out", 32'(done), 32'(ch));
    endtask

    // Reference model: frame decision time d, end time e; everything else follows
    // from the cycle numbers (launch at d+1, waiting from d+2, gap after e).
    int           cyc = 0;
    bit           mon = 0;
    bit           m_pend [2];
    logic [W-1:0] m_sval [2];
    int           m_last = 1;
    int           m_gnt = 0;
    bit           m_frame = 0;
    int           m_d = 0;
    int           m_e = -1;
    logic [W-1:0] m_spi = '0;
    logic [1:0]   m_done = '0;
    logic [1:0]   m_ovr = '0;
    bit           m_tmo = 0;

    // Scoreboard: compare every output against the model, then advance the model
    always @(negedge clk) begin
        bit           act;
        bit           strob_e;
        bit           wait_e;
        logic [1:0]   load_e;
        logic [1:0]   busy_e;
        logic [1:0]   gbit;
        int           sel;
        bit           wg;
        logic [W-1:0] vg;

        cyc++;
        act     = m_frame && (cyc >= m_d + 1) && (m_e < 0 || cyc <= m_e + GP);
        strob_e = m_frame && (cyc == m_d + 1);
        wait_e  = m_frame && (cyc >= m_d + 2) && (m_e < 0);
        gbit    = (m_gnt == 1) ? 2'b10 : 2'b01;
        load_e  = (wait_e && load) ? gbit : 2'b00;
        busy_e  = {m_pend[1], m_pend[0]} | (act ? gbit : 2'b00);

        if (mon) begin
            chk("m_spi_value", 32'(spi_value), 32'(m_spi));
            chk("m_spi_strob", 32'(spi_strob), 32'(strob_e));
            chk("m_load_out",  32'(load_out),  32'(load_e));
            chk("m_busy",      32'(busy),      32'(busy_e));
            chk("m_done",      32'(done),      32'(m_done));
            chk("m_overrun",   32'(overrun),   32'(m_ovr));
            chk("m_timeout",   32'(timeout),   32'(m_tmo));
        end

        if (rst) begin
            mon       = 1;
            m_pend[0] = 0;
            m_pend[1] = 0;
            m_sval[0] = '0;
            m_sval[1] = '0;
            m_last    = 1;
            m_gnt     = 0;
            m_frame   = 0;
            m_e       = -1;
            m_spi     = '0;
            m_done    = '0;
            m_ovr     = '0;
            m_tmo     = 0;
        end else begin
            if (clr) begin
                m_ovr = '0;
                m_tmo = 0;
            end
            m_done = 2'b00;
            if (wait_e && load) begin
                m_done = gbit;
                m_e    = cyc;
            end else if (wait_e && cyc == m_d + 1 + TMO) begin
                m_tmo = 1;
                m_e   = cyc;
            end
            if (!act && (m_pend[0] || m_pend[1])) begin
                sel         = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
                m_gnt       = sel;
                m_last      = sel;
                m_spi       = m_sval[sel];
                m_pend[sel] = 0;
                m_frame     = 1;
                m_d         = cyc;
                m_e         = -1;
            end
            for (int g = 0; g < 2; g++) begin
                wg = (g == 0) ? wr0 : wr1;
                vg = (g == 0) ? v0 : v1;
                if (wg) begin
                    if (!m_pend[g]) begin
                        m_sval[g] = vg;
                        m_pend[g] = 1;
                    end else begin
`ifdef DAC_ARB_COALESCE_EN
                        m_sval[g] = vg;
`else
                        m_ovr[g] = 1'b1;
`endif
                    end
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        int n;
        int k;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_spi_value", 32'(spi_value), 32'h0);
        chk("rst_strob",     32'(spi_strob), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_done",      32'(done),      32'h0);
        chk("rst_overrun",   32'(overrun),   32'h0);
        chk("rst_timeout",   32'(timeout),   32'h0);

        // 1: single write, launch latency, load routing, gap before the next launch
        step(); wr0 = 1'b1; v0 = 10'h155;
        @(negedge clk);
        chk("t1_strob_t0", 32'(spi_strob), 32'h0);
        step();
        @(negedge clk);
        chk("t1_strob_t1", 32'(spi_strob), 32'h0);
        chk("t1_busy_t1",  32'(busy),      32'h1);
        step();
        @(negedge clk);
        chk("t1_strob_t2", 32'(spi_strob), 32'h1);
        chk("t1_value",    32'(spi_value), 32'h155);
        repeat (19) step();
        step(); load = 1'b1; wr1 = 1'b1; v1 = 10'h2AA;
        @(negedge clk);
        chk("t1_load_out", 32'(load_out), 32'h1);
        step();
        @(negedge clk);
        chk("t1_done", 32'(done), 32'h1);
        wait_strobe(n);
        chk("t1_regrant_after_load", 32'(n + 1), 32'd6);
        chk("t1_value2", 32'(spi_value), 32'h2AA);
        finish(3, 2'b10);

        // 2: simultaneous writes, channel 0 first twice in a row
        for (int r = 0; r < 2; r++) begin
            step(); wr0 = 1'b1; v0 = 10'h001; wr1 = 1'b1; v1 = 10'h3FF;
            wait_strobe(n);
            chk("t2_first_value", 32'(spi_value), 32'h001);
            finish(2, 2'b01);
            wait_strobe(n);
            chk("t2_second_value", 32'(spi_value), 32'h3FF);
            finish(2, 2'b10);
        end

        // 3: both channels kept pending for six frames
        step(); wr0 = 1'b1; v0 = 10'h100; wr1 = 1'b1; v1 = 10'h200;
        for (int i = 0; i < 6; i++) begin
            wait_strobe(n);
            chk("t3_rr_grant", 32'(spi_value[9:8]), (i % 2 == 1) ? 32'h2 : 32'h1);
            step();
            if (i < 4) begin
                if (i % 2 == 0) begin wr0 = 1'b1; v0 = 10'h100 + 10'(i + 1); end
                else            begin wr1 = 1'b1; v1 = 10'h200 + 10'(i + 1); end
            end
            finish(2, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        repeat (GP + 2) step();

        // 4: timeout with no load pulse, then clear
        step(); wr0 = 1'b1; v0 = 10'h0AA;
        wait_strobe(n);
        chk("t4_strobe_latency", 32'(n), 32'd2);
        k = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            @(negedge clk);
            k++;
            if (timeout) break;
        end
        chk("t4_timeout_latency", 32'(k), 32'(TMO + 1));
        repeat (GP + 2) step();
        @(negedge clk);
        chk("t4_busy_after_gap", 32'(busy), 32'h0);
        chk("t4_timeout_sticky", 32'(timeout), 32'h1);
        step(); clr = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t4_timeout_clr", 32'(timeout), 32'h0);

        // 5: second write to a pending channel
        step(); wr0 = 1'b1; v0 = 10'h0F0;
        @(negedge clk);
        step(); wr1 = 1'b1; v1 = 10'h010;
        @(negedge clk);
        step(); wr1 = 1'b1; v1 = 10'h020;
        @(negedge clk);
        chk("t5_strob", 32'(spi_strob), 32'h1);
        chk("t5_value0", 32'(spi_value), 32'h0F0);
        finish(3, 2'b01);
`ifdef DAC_ARB_COALESCE_EN
        chk("t5_overrun", 32'(overrun), 32'h0);
`else
        chk("t5_overrun", 32'(overrun), 32'h2);
`endif
        wait_strobe(n);
`ifdef DAC_ARB_COALESCE_EN
        chk("t5_value1", 32'(spi_value), 32'h020);
`else
        chk("t5_value1", 32'(spi_value), 32'h010);
`endif
        finish(2, 2'b10);
        step(); clr = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t5_overrun_clr", 32'(overrun), 32'h0);
        repeat (GP + 2) step();

        // 6: reset while waiting for load, then normal operation
        step(); wr0 = 1'b1; v0 = 10'h123;
        wait_strobe(n);
        step();
        step(); rst = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t6_spi_value", 32'(spi_value), 32'h0);
        chk("t6_strob",     32'(spi_strob), 32'h0);
        chk("t6_busy",      32'(busy),      32'h0);
        chk("t6_done",      32'(done),      32'h0);
        chk("t6_load_out",  32'(load_out),  32'h0);
        repeat (5) step();
        step(); wr1 = 1'b1; v1 = 10'h2AA;
        wait_strobe(n);
        chk("t6_strobe_latency", 32'(n), 32'd2);
        chk("t6_value", 32'(spi_value), 32'h2AA);
        finish(4, 2'b10);
        repeat (GP + 3) step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
